// File: rtl/mod_sseg_mux_pkg.sv
// mod_sseg_mux_pkg: register map, CTRL layout and hex segment table for the display mux
package mod_sseg_mux_pkg;
  localparam logic [1:0] REG_DATA_LO = 2'd0;
  localparam logic [1:0] REG_DATA_HI = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;
  localparam logic [31:0] CTRL_MASK = 32'h0FFF_FF01;
  typedef struct packed {
    logic [3:0] rsv_hi;
    logic [3:0] bright;
    logic [7:0] dp;
    logic [7:0] en;
    logic [6:0] rsv_lo;
    logic       mode;
  } ctrl_t;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/mod_sseg_mux_hex_decode.sv
// mod_sseg_mux_hex_decode: nibble plus dp to active-high {dp,g..a} pattern
module mod_sseg_mux_hex_decode
  import mod_sseg_mux_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);
  assign seg_o = {dp_i, HEX_SEG[nib_i]};
endmodule

// File: rtl/mod_sseg_mux.sv
// mod_sseg_mux: bus-mapped multiplexed seven-segment controller with hex decode and PWM
module mod_sseg_mux
  import mod_sseg_mux_pkg::*;
#(
  parameter int CLOCK_FREQ     = 50000000,
  parameter int DIGITS         = 4,
  parameter int REFRESH_HZ     = 60,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ie,
  input  logic              de,
  input  logic [31:0]       iaddr,
  input  logic [31:0]       daddr,
  input  logic              drw,
  input  logic [31:0]       din,
  output logic [31:0]       iout,
  output logic [31:0]       dout,
  output logic [DIGITS-1:0] sseg_an,
  output logic [7:0]        sseg_display
);
  localparam int TICKS = CLOCK_FREQ / (REFRESH_HZ * DIGITS);
  localparam int SW = TICKS > 1 ? $clog2(TICKS) : 1;
  localparam logic [DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] EN_RST = 8'((1 << DIGITS) - 1);
  localparam ctrl_t CTRL_RST = '{rsv_hi: 4'h0, bright: 4'hF, dp: 8'h00, en: EN_RST, rsv_lo: 7'h00, mode: 1'b0};
  logic [31:0] data_lo_q, data_lo_d, data_hi_q, data_hi_d, rd;
  ctrl_t ctrl_q, ctrl_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [2:0] dig_q, dig_d;
  logic [15:0] frame_q, frame_d;
  logic [3:0] pwm_q, nib;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0] seg_q, seg_d, raw_byte, hex_seg, hex_pins;
  logic wr, slot_end, dig_end, lit, unused_ok;
  assign unused_ok = ^{iaddr, daddr[31:4], daddr[1:0]};
  mod_sseg_mux_hex_decode u_hex (
    .nib_i(nib),
    .dp_i (ctrl_q.dp[dig_q]),
    .seg_o(hex_seg)
  );
  // next-state for registers, scan counters and the registered display drive
  always_comb begin
    wr        = de && drw;
    data_lo_d = (wr && daddr[3:2] == REG_DATA_LO) ? din : data_lo_q;
    data_hi_d = (wr && daddr[3:2] == REG_DATA_HI) ? din : data_hi_q;
    ctrl_d    = (wr && daddr[3:2] == REG_CTRL) ? ctrl_t'(din & CTRL_MASK) : ctrl_q;
    slot_end  = slot_q == SW'(TICKS - 1);
    dig_end   = dig_q == 3'(DIGITS - 1);
    slot_d    = slot_end ? '0 : slot_q + SW'(1);
    dig_d     = slot_end ? (dig_end ? 3'd0 : dig_q + 3'd1) : dig_q;
    frame_d   = frame_q + 16'(slot_end && dig_end);
    raw_byte  = 8'((dig_q[2] ? data_hi_q : data_lo_q) >> {dig_q[1:0], 3'b000});
    nib       = 4'(data_lo_q >> {dig_q, 2'b00});
    hex_pins  = SEG_ACTIVE_LOW ? ~hex_seg : hex_seg;
    lit       = ctrl_q.en[dig_q] && pwm_q <= ctrl_q.bright;
    an_d      = lit ? AN_OFF ^ (DIGITS'(1) << dig_q) : AN_OFF;
    seg_d     = lit ? (ctrl_q.mode ? hex_pins : raw_byte) : SEG_OFF;
    rd        = daddr[3:2] == REG_DATA_LO ? data_lo_q :
                daddr[3:2] == REG_DATA_HI ? data_hi_q :
                daddr[3:2] == REG_CTRL    ? ctrl_q    : {frame_q, 13'd0, dig_q};
  end
  assign iout = ie ? 32'd0 : 32'bz;
  assign dout = de ? rd : 32'bz;
  assign sseg_an = an_q;
  assign sseg_display = seg_q;
  // falling-edge state update; reset wins over a simultaneous bus write
  always_ff @(negedge clk) begin
    if (rst) begin
      data_lo_q <= '0;
      data_hi_q <= '0;
      ctrl_q    <= CTRL_RST;
      slot_q    <= '0;
      dig_q     <= '0;
      frame_q   <= '0;
      pwm_q     <= '0;
      an_q      <= AN_OFF ^ DIGITS'(1);
      seg_q     <= 8'h00;
    end else begin
      data_lo_q <= data_lo_d;
      data_hi_q <= data_hi_d;
      ctrl_q    <= ctrl_d;
      slot_q    <= slot_d;
      dig_q     <= dig_d;
      frame_q   <= frame_d;
      pwm_q     <= pwm_q + 4'd1;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end
endmodule

// File: tb/tb_mod_sseg_mux.sv
// tb_mod_sseg_mux: randomized and directed checks of the display mux against a cycle-count model
module tb_mod_sseg_mux;
  localparam int TICKS = 10;
  localparam int ND = 4;
  localparam logic [6:0] HEX_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic clk = 1'b0, rst = 1'b0, ie = 1'b0, de = 1'b0, drw = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, din = '0;
  tri1 [31:0] iout, dout;
  wire [3:0] an;
  wire [7:0] seg;
  int n_vec = 0, n_err = 0, n = 0;
  logic [31:0] m_lo, m_hi, m_ctrl;
  logic [3:0] e_an;
  logic [7:0] e_seg;
  mod_sseg_mux #(.CLOCK_FREQ(2400), .DIGITS(ND), .REFRESH_HZ(60), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .ie(ie), .de(de), .iaddr(iaddr), .daddr(daddr), .drw(drw), .din(din),
    .iout(iout), .dout(dout), .sseg_an(an), .sseg_display(seg)
  );
  always #5 clk = ~clk;
  function automatic int m_dig(int k);
    return (k / TICKS) % ND;
  endfunction
  function automatic bit m_lit(int k);
    return m_ctrl[8 + m_dig(k)] && (k % 16) <= int'(m_ctrl[27:24]);
  endfunction
  function automatic logic [3:0] m_an(int k);
    return m_lit(k) ? ~(4'b0001 << m_dig(k)) : 4'hF;
  endfunction
  function automatic logic [7:0] m_seg(int k);
    int d = m_dig(k);
    if (!m_lit(k)) return 8'hFF;
    if (!m_ctrl[0]) return d < 4 ? m_lo[8*d +: 8] : m_hi[8*(d-4) +: 8];
    return ~{m_ctrl[16 + d], HEX_TAB[m_lo[4*d +: 4]]};
  endfunction
  function automatic logic [31:0] m_reg(int a);
    logic [15:0] fr = 16'((n / (TICKS * ND)) % 65536);
    return a == 0 ? m_lo : a == 1 ? m_hi : a == 2 ? m_ctrl : {fr, 13'd0, 3'(m_dig(n))};
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0; drw = 1'b0; n = 0;
    m_lo = '0; m_hi = '0; m_ctrl = 32'h0F00_0F00;
    e_an = 4'b1110; e_seg = 8'h00;
  endtask
  task automatic cyc(input bit w, input int a, input logic [31:0] d);
    e_an = m_an(n); e_seg = m_seg(n);
    de = 1'b1; daddr = {28'd0, 2'(a), 2'b00}; din = d; drw = w;
    @(negedge clk); #1;
    drw = 1'b0;
    if (w && a == 0) m_lo = d;
    if (w && a == 1) m_hi = d;
    if (w && a == 2) m_ctrl = d & 32'h0FFF_FF01;
    n++;
  endtask
  task automatic test_reset();
    do_reset();
    n_vec++; if (an !== 4'b1110) begin n_err++; $display("FAIL reset_an: got %b want 1110", an); end
    n_vec++; if (seg !== 8'h00) begin n_err++; $display("FAIL reset_seg: got %h want 00", seg); end
    de = 1'b1; daddr = 32'h8; #1;
    n_vec++; if (dout !== 32'h0F00_0F00) begin n_err++; $display("FAIL reset_ctrl: got %h want 0F000F00", dout); end
    daddr = 32'hC; #1;
    n_vec++; if (dout !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", dout); end
    daddr = 32'h8; de = 1'b0; #1;
    n_vec++; if (dout !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dout_release: got %h want pulled-up", dout); end
    ie = 1'b0; #1;
    n_vec++; if (iout !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL iout_release: got %h want pulled-up", iout); end
    ie = 1'b1; #1;
    n_vec++; if (iout !== 32'h0) begin n_err++; $display("FAIL iout_drive: got %h want 0", iout); end
    ie = 1'b0; de = 1'b1;
  endtask
  task automatic test_scan();
    do_reset();
    repeat (10) cyc(0, 3, 0);
    n_vec++; if (dout !== 32'h1) begin n_err++; $display("FAIL scan_status10: got %h want 1", dout); end
    cyc(0, 3, 0);
    n_vec++; if (an !== 4'b1101) begin n_err++; $display("FAIL scan_an11: got %b want 1101", an); end
    repeat (29) cyc(0, 3, 0);
    n_vec++; if (dout !== 32'h0001_0000) begin n_err++; $display("FAIL scan_frame: got %h want 00010000", dout); end
    cyc(0, 3, 0);
    n_vec++; if (an !== 4'b1110) begin n_err++; $display("FAIL scan_an41: got %b want 1110", an); end
  endtask
  task automatic test_raw();
    do_reset();
    cyc(1, 0, 32'hC0F9_A4B0);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0);
      n_vec++; if (an !== e_an || seg !== e_seg) begin n_err++; $display("FAIL raw_scan k=%0d: got %b/%h want %b/%h", n-1, an, seg, e_an, e_seg); end
      if (n - 1 == 2) begin n_vec++; if (seg !== 8'hB0) begin n_err++; $display("FAIL raw_d0: got %h want B0", seg); end end
      if (n - 1 == 12) begin n_vec++; if (seg !== 8'hA4) begin n_err++; $display("FAIL raw_d1: got %h want A4", seg); end end
      if (n - 1 == 32) begin n_vec++; if (seg !== 8'hC0) begin n_err++; $display("FAIL raw_d3: got %h want C0", seg); end end
    end
  endtask
  task automatic test_hex();
    do_reset();
    cyc(1, 2, 32'h0F01_0F01);
    cyc(1, 0, 32'h0000_000F);
    cyc(0, 0, 0);
    n_vec++; if (seg !== 8'h0E) begin n_err++; $display("FAIL hex_dp: got %h want 0E", seg); end
    cyc(1, 2, 32'h0F00_0F01);
    cyc(0, 0, 0);
    n_vec++; if (seg !== 8'h8E) begin n_err++; $display("FAIL hex_nodp: got %h want 8E", seg); end
    cyc(1, 2, 32'h0F00_0F00);
    cyc(0, 0, 0);
    n_vec++; if (seg !== 8'h0F || seg !== e_seg) begin n_err++; $display("FAIL hex_to_raw: got %h want 0F", seg); end
  endtask
  task automatic test_blank_pwm();
    int cnt = 0;
    do_reset();
    cyc(1, 2, 32'h0F00_0D00);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0);
      n_vec++; if (an !== e_an || seg !== e_seg) begin n_err++; $display("FAIL blank_scan k=%0d: got %b/%h want %b/%h", n-1, an, seg, e_an, e_seg); end
      if (m_dig(n - 1) == 1) begin n_vec++; if (an !== 4'hF || seg !== 8'hFF) begin n_err++; $display("FAIL blank_d1: got %b/%h want 1111/FF", an, seg); end end
    end
    cyc(1, 2, 32'h0300_0F00);
    cyc(0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0);
      if (an !== 4'hF) cnt++;
      n_vec++; if (an !== e_an) begin n_err++; $display("FAIL pwm_an k=%0d: got %b want %b", n-1, an, e_an); end
    end
    n_vec++; if (cnt != 4) begin n_err++; $display("FAIL pwm_duty: got %0d want 4", cnt); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int a = int'($urandom_range(0, 3));
      int ra = int'($urandom_range(0, 3));
      cyc($urandom_range(0, 7) == 0, a, $urandom);
      n_vec++; if (an !== e_an || seg !== e_seg) begin n_err++; $display("FAIL rand_out k=%0d: got %b/%h want %b/%h", n-1, an, seg, e_an, e_seg); end
      daddr = {28'd0, 2'(ra), 2'b00}; #1;
      n_vec++; if (dout !== m_reg(ra)) begin n_err++; $display("FAIL rand_read a=%0d: got %h want %h", ra, dout, m_reg(ra)); end
    end
  endtask
  task automatic test_rst_prio();
    do_reset();
    cyc(1, 0, 32'h1234_5678);
    de = 1'b1; drw = 1'b1; daddr = 32'h0; din = 32'hDEAD_BEEF;
    do_reset();
    daddr = 32'h0; #1;
    n_vec++; if (dout !== 32'h0) begin n_err++; $display("FAIL rst_prio: got %h want 0", dout); end
    cyc(1, 3, 32'hFFFF_FFFF);
    n_vec++; if (dout !== 32'h0 || dout !== m_reg(3)) begin n_err++; $display("FAIL status_ro: got %h want 0", dout); end
    repeat (12) cyc(0, 3, 0);
    n_vec++; if (dout !== m_reg(3)) begin n_err++; $display("FAIL status_after: got %h want %h", dout, m_reg(3)); end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_raw();
    test_hex();
    test_blank_pwm();
    test_random();
    test_rst_prio();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
